negator: RTL and testbench
==========================

NEGATOR -- requirements
Module: negator

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; legal values 2..64.
REQ-002 Parameter SATURATE, default 0: 0 = wrap on most-negative input, 1 = clamp result to the most-positive value.
REQ-003 CLK  input  1  single clock; all sequential logic updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the rising CLK edge.
REQ-005 in  input  WIDTH  signed two's-complement operand.
REQ-006 out  output  WIDTH  signed combinational negation of in.
REQ-007 in_valid  input  1  qualifies in for capture into the registered stage.
REQ-008 out_q  output  WIDTH  registered negation of the last captured operand.
REQ-009 out_valid  output  1  out_q holds a result captured on the previous edge.
REQ-010 ovf  output  1  registered flag: the captured operand was the most-negative value.
REQ-011 zero  output  1  registered flag: out_q equals 0.
REQ-012 neg  output  1  registered flag: out_q MSB, i.e. the result is negative.

Function
REQ-013 out SHALL equal (~in + 1) truncated to WIDTH bits, purely combinational, with zero latency and no dependence on CLK or RESET.
REQ-014 When SATURATE=1 and in is the most-negative value (-2^(WIDTH-1)), out SHALL be 2^(WIDTH-1)-1.
REQ-015 When SATURATE=0 and in is the most-negative value, out SHALL equal in (wrap), e.g. -128 -> -128 for WIDTH=8.
REQ-016 The value 0 SHALL negate to 0 and SHALL NOT flag ovf.
REQ-017 On a rising edge with RESET=0 and in_valid=1, out_q SHALL load the REQ-013..015 result for in, and ovf, zero and neg SHALL update in the same edge.
REQ-018 On a rising edge with RESET=0 and in_valid=0, out_q, ovf, zero and neg SHALL hold their values.
REQ-019 out_valid SHALL equal the in_valid value sampled on the previous edge (one-cycle latency); a stream of back-to-back in_valid=1 cycles SHALL give one result per cycle, with no backpressure.
REQ-020 The ovf flag SHALL be set regardless of SATURATE whenever the captured operand is the most-negative value.
REQ-021 The zero and neg flags SHALL reflect the value actually loaded into out_q, including the saturated value.

Reset
REQ-022 While RESET=1 at an edge, out_q SHALL be 0, out_valid 0, ovf 0, zero 1 and neg 0, regardless of in_valid.
REQ-023 RESET SHALL have priority over in_valid; an operand presented in the reset cycle SHALL be discarded.
REQ-024 The combinational out SHALL stay functional during reset.
REQ-025 After RESET is released, the first capture SHALL occur on the first edge with in_valid=1.

Verification
REQ-026 Combinational sweep, WIDTH=8: in=45 -> out=-45; in=20 -> out=-20; in=-3 -> out=3; in=-48 -> out=48; no clock required.
REQ-027 Boundary values: in=0 -> out=0; in=127 -> out=-127; in=-128 -> out=-128 (SATURATE=0) or 127 (SATURATE=1), with ovf=1 after capture in both modes.
REQ-028 Pipeline: in_valid=1 for three cycles with in=5,-7,0 -> out_q=-5,7,0 on the following edges, out_valid=1 for exactly three cycles, zero=1 only for the last result.
REQ-029 Hold: capture in=10, then in_valid=0 with in changing -> out_q stays -10 and out_valid drops to 0.
REQ-030 Reset mid-stream: RESET=1 while in_valid=1, in=33 -> next edge gives out_q=0, out_valid=0, zero=1; capture resumes after release.
REQ-031 Exhaustive check: all 256 inputs at WIDTH=8, compared against a reference negation in both SATURATE modes.

Source files
------------

// File: rtl/negator.sv
// Two's-complement negator with a combinational result and one registered,
// valid-qualified stage carrying overflow / zero / sign flags.
module negator #(
  parameter int WIDTH    = 8,  // 2..64
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic             is_min;
  logic [WIDTH-1:0] wrapped;

  // -MIN is not representable: wrapping yields MIN again, saturating clamps to MAX.
  assign is_min  = (in == MOST_NEG);
  assign wrapped = ~in + {{(WIDTH-1){1'b0}}, 1'b1};
  assign out     = (SATURATE && is_min) ? MOST_POS : wrapped;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      neg       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
        ovf   <= is_min;
        zero  <= (out == '0);
        neg   <= out[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_negator.sv
// Directed bench for negator: both SATURATE modes side by side, scoreboard of
// captured operands, exhaustive 8-bit sweep.
module tb_negator;

  typedef struct {
    logic [7:0] q0;
    logic [7:0] q1;
    logic       ovf;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] din;
  logic       in_valid;

  logic [7:0] out0, out_q0, out1, out_q1;
  logic       vld0, ovf0, zero0, neg0;
  logic       vld1, ovf1, zero1, neg1;

  exp_t       sb[$];
  exp_t       last;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 CLK = ~CLK;

  negator #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .RESET(RESET), .in(din), .in_valid(in_valid),
    .out(out0), .out_q(out_q0), .out_valid(vld0),
    .ovf(ovf0), .zero(zero0), .neg(neg0)
  );

  negator #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RESET(RESET), .in(din), .in_valid(in_valid),
    .out(out1), .out_q(out_q1), .out_valid(vld1),
    .ovf(ovf1), .zero(zero1), .neg(neg1)
  );

  function automatic logic [7:0] ref_neg(input logic [7:0] x, input bit sat);
    int v;
    v = $signed(x);
    if (v == -128) return sat ? 8'sd127 : 8'h80;
    v = 0 - v;
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input logic [7:0] d);
    din = d;
    #1;
    chk("comb_wrap", 64'(out0), 64'(ref_neg(d, 1'b0)));
    chk("comb_sat",  64'(out1), 64'(ref_neg(d, 1'b1)));
  endtask

  task automatic chk_regs();
    chk("q_wrap",    64'(out_q0), 64'(last.q0));
    chk("q_sat",     64'(out_q1), 64'(last.q1));
    chk("ovf_wrap",  64'(ovf0),   64'(last.ovf));
    chk("ovf_sat",   64'(ovf1),   64'(last.ovf));
    chk("zero_wrap", 64'(zero0),  64'(last.q0 == 8'h00));
    chk("zero_sat",  64'(zero1),  64'(last.q1 == 8'h00));
    chk("neg_wrap",  64'(neg0),   64'(last.q0[7]));
    chk("neg_sat",   64'(neg1),   64'(last.q1[7]));
  endtask

  // One clock: drive, check comb, push expectation, clock, pop and check.
  task automatic step(input bit r, input bit v, input logic [7:0] d);
    exp_t e;
    bit   exp_vld;
    RESET    = r;
    in_valid = v;
    chk_comb(d);
    exp_vld = !r && v;
    if (exp_vld) begin
      e.q0  = ref_neg(d, 1'b0);
      e.q1  = ref_neg(d, 1'b1);
      e.ovf = (d == 8'h80);
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    chk("vld_wrap", 64'(vld0), 64'(exp_vld));
    chk("vld_sat",  64'(vld1), 64'(exp_vld));
    if (r) begin
      last.q0 = 8'h00; last.q1 = 8'h00; last.ovf = 1'b0;
    end else if (vld0 && sb.size() > 0) begin
      last = sb.pop_front();
    end
    chk_regs();
  endtask

  initial begin
    RESET = 1'b1; in_valid = 1'b0; din = 8'h00;
    last.q0 = 8'h00; last.q1 = 8'h00; last.ovf = 1'b0;

    // combinational sweep and boundaries before any clock edge
    chk_comb(8'd45);
    chk_comb(8'd20);
    chk_comb(8'hFD);
    chk_comb(8'hD0);
    chk_comb(8'd0);
    chk_comb(8'd127);
    chk_comb(8'h80);

    // reset with an operand presented: must be discarded
    step(1'b1, 1'b1, 8'd33);
    step(1'b1, 1'b0, 8'd12);

    // pipeline 5, -7, 0 back to back, then idle
    step(1'b0, 1'b1, 8'd5);
    step(1'b0, 1'b1, 8'hF9);
    step(1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b0, 8'd99);

    // hold: capture 10, then in changes with in_valid low
    step(1'b0, 1'b1, 8'd10);
    step(1'b0, 1'b0, 8'd77);
    step(1'b0, 1'b0, 8'h80);

    // boundaries through the register
    step(1'b0, 1'b1, 8'd127);
    step(1'b0, 1'b1, 8'h80);
    step(1'b0, 1'b0, 8'd1);
    step(1'b0, 1'b1, 8'd0);

    // reset mid-stream, then resume
    step(1'b0, 1'b1, 8'd3);
    step(1'b1, 1'b1, 8'd33);
    step(1'b0, 1'b0, 8'd44);
    step(1'b0, 1'b1, 8'd44);

    // exhaustive sweep, one operand per cycle
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 8'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
